// File: rtl/matmul_operand_loader_if.sv
// Byte-stream handshake between the host/DMA source and the operand loader.
interface matmul_operand_loader_if #(
  parameter int unsigned DW = 8
) ();
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/matmul_operand_loader.sv
// Loads operand vectors A and B from a byte stream, serves them through registered
// read ports, then pulses mm_start and waits for mm_done from the dot-product engine.
module matmul_operand_loader #(
  parameter  int unsigned N  = 70,
  parameter  int unsigned DW = 8,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_arm,
  matmul_operand_loader_if.slave  s_if,
  input  logic [AW-1:0]           i_rd_addr_a,
  output logic [DW-1:0]           o_rd_data_a,
  input  logic [AW-1:0]           i_rd_addr_b,
  output logic [DW-1:0]           o_rd_data_b,
  output logic                    o_mm_start,
  input  logic                    i_mm_done,
  output logic                    o_busy,
  output logic                    o_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_START, ST_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_wr_idx;
  logic          r_s_ready;
  logic          r_mm_start;
  logic          r_busy;
  logic          r_err;
  logic          w_s_ready_nxt;
  logic          w_mm_start_nxt;
  logic          w_busy_nxt;
  logic          w_accept;
  logic          w_idx_last;
  logic          w_final_beat;
  logic [DW-1:0] r_mem_a [N];
  logic [DW-1:0] r_mem_b [N];
  logic [DW-1:0] r_rd_data_a;
  logic [DW-1:0] r_rd_data_b;

  // r_s_ready is high exactly in LOAD_A/LOAD_B, so an accept implies a load state
  assign w_accept     = s_if.s_valid & r_s_ready;
  assign w_idx_last   = (r_wr_idx == AW'(N - 1));
  assign w_final_beat = (r_state == ST_LOAD_B) & w_idx_last;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_arm)                   w_state_nxt = ST_LOAD_A;
      ST_LOAD_A: if (w_accept && w_idx_last)  w_state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (w_accept && w_idx_last)  w_state_nxt = ST_START;
      ST_START:                               w_state_nxt = ST_WAIT;
      ST_WAIT:   if (i_mm_done)               w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with r_state
  always_comb begin
    w_s_ready_nxt  = 1'b0;
    w_mm_start_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_s_ready_nxt  = (w_state_nxt == ST_LOAD_A) || (w_state_nxt == ST_LOAD_B);
    w_mm_start_nxt = (w_state_nxt == ST_START);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s_ready  <= 1'b0;
      r_mm_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_s_ready  <= w_s_ready_nxt;
      r_mm_start <= w_mm_start_nxt;
      r_busy     <= w_busy_nxt;
      // Framing error: s_last must coincide exactly with B[N-1]; the load never resyncs
      if (w_accept && (s_if.s_last != w_final_beat)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE:   if (i_arm) r_wr_idx <= '0;
        ST_LOAD_A: if (w_accept) r_wr_idx <= w_idx_last ? '0 : r_wr_idx + AW'(1);
        ST_LOAD_B: if (w_accept && !w_idx_last) r_wr_idx <= r_wr_idx + AW'(1);
        default:   r_wr_idx <= r_wr_idx;
      endcase
    end
  end

  // Operand storage is never cleared by reset
  always_ff @(posedge clk) begin
    if (resetn && w_accept && (r_state == ST_LOAD_A)) r_mem_a[r_wr_idx] <= s_if.s_data;
    if (resetn && w_accept && (r_state == ST_LOAD_B)) r_mem_b[r_wr_idx] <= s_if.s_data;
  end

  // Read ports return pre-write data on a same-cycle address collision
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
    end else begin
      r_rd_data_a <= r_mem_a[i_rd_addr_a];
      r_rd_data_b <= r_mem_b[i_rd_addr_b];
    end
  end

  assign s_if.s_ready = r_s_ready;
  assign o_mm_start   = r_mm_start;
  assign o_busy       = r_busy;
  assign o_err        = r_err;
  assign o_rd_data_a  = r_rd_data_a;
  assign o_rd_data_b  = r_rd_data_b;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for matmul_operand_loader: framing, stalls, mm_done handling,
// mid-load reset and read-before-write on the operand memories.
module tb_matmul_operand_loader;

  localparam int N  = 70;
  localparam int DW = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_arm;
  logic [AW-1:0] i_rd_addr_a;
  logic [AW-1:0] i_rd_addr_b;
  logic [DW-1:0] o_rd_data_a;
  logic [DW-1:0] o_rd_data_b;
  logic          o_mm_start;
  logic          i_mm_done;
  logic          o_busy;
  logic          o_err;

  int n_checks = 0;
  int n_fail   = 0;

  matmul_operand_loader_if #(.DW(DW)) u_if ();

  matmul_operand_loader #(.N(N), .DW(DW)) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_arm       (i_arm),
    .s_if        (u_if),
    .i_rd_addr_a (i_rd_addr_a),
    .o_rd_data_a (o_rd_data_a),
    .i_rd_addr_b (i_rd_addr_b),
    .o_rd_data_b (o_rd_data_b),
    .o_mm_start  (o_mm_start),
    .i_mm_done   (i_mm_done),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame byte at stream position beat (0..2N-1) for a given data pattern
  function automatic logic [7:0] val(input int mode, input int beat);
    int  idx;
    bit  is_b;
    is_b = (beat >= N);
    idx  = is_b ? beat - N : beat;
    case (mode)
      1:       return is_b ? 8'(200 - idx) : 8'(64 + idx);
      2:       return is_b ? 8'(idx) : 8'h11;
      default: return 8'(idx + 1);
    endcase
  endfunction

  // Streams one frame from arm; counts mm_start pulses and the edge index of the first
  task automatic run_frame(input int mode, input bit gaps, input int last_beat,
                           input int done_beat, output int n_start,
                           output int start_cyc, output bit timed_out);
    int beat = 0;
    int cyc  = 0;
    bit acc;
    n_start   = 0;
    start_cyc = -1;
    i_arm     = 1'b1;
    while (beat < 2 * N && cyc < 4000) begin
      u_if.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      u_if.s_data  = val(mode, beat);
      u_if.s_last  = (beat == last_beat);
      i_mm_done    = (beat == done_beat);
      acc          = u_if.s_valid && u_if.s_ready;
      step();
      cyc++;
      i_arm = 1'b0;
      if (acc) beat++;
      if (o_mm_start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = cyc;
      end
    end
    u_if.s_valid = 1'b0;
    u_if.s_last  = 1'b0;
    i_mm_done    = 1'b0;
    timed_out    = (beat < 2 * N);
    repeat (3) begin
      step();
      if (o_mm_start) n_start++;
    end
  endtask

  task automatic finish_frame();
    i_mm_done = 1'b1;
    step();
    i_mm_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_arm = 1'b0; i_mm_done = 1'b0;
    u_if.s_valid = 1'b0; u_if.s_data = '0; u_if.s_last = 1'b0;
    i_rd_addr_a = '0; i_rd_addr_b = '0;
    repeat (3) step();
    n_checks += 6;
    if (u_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=0", u_if.s_ready); end
    if (o_mm_start !== 1'b0)   begin n_fail++; $display("FAIL reset_mm_start got=%b exp=0", o_mm_start); end
    if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    if (o_err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got=%b exp=0", o_err); end
    if (o_rd_data_a !== 8'h00) begin n_fail++; $display("FAIL reset_rd_a got=%h exp=00", o_rd_data_a); end
    if (o_rd_data_b !== 8'h00) begin n_fail++; $display("FAIL reset_rd_b got=%h exp=00", o_rd_data_b); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    int ns, sc; bit to;
    run_frame(0, 1'b0, 2 * N - 1, -1, ns, sc, to);
    n_checks += 6;
    if (to !== 1'b0)          begin n_fail++; $display("FAIL nom_timeout got=%b exp=0", to); end
    if (ns != 1)              begin n_fail++; $display("FAIL nom_start_count got=%0d exp=1", ns); end
    if (sc != 2 * N + 1)      begin n_fail++; $display("FAIL nom_start_edge got=%0d exp=%0d", sc, 2 * N + 1); end
    if (o_busy !== 1'b1)      begin n_fail++; $display("FAIL nom_busy got=%b exp=1", o_busy); end
    if (o_err !== 1'b0)       begin n_fail++; $display("FAIL nom_err got=%b exp=0", o_err); end
    if (u_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL nom_wait_ready got=%b exp=0", u_if.s_ready); end
    i_rd_addr_a = 7'd5;
    step();
    n_checks++;
    if (o_rd_data_a !== 8'd6) begin n_fail++; $display("FAIL nom_rd_a5 got=%h exp=06", o_rd_data_a); end
    for (int i = 0; i < N; i++) begin
      i_rd_addr_a = 7'(i); i_rd_addr_b = 7'(i);
      step();
      n_checks += 2;
      if (o_rd_data_a !== val(0, i))     begin n_fail++; $display("FAIL nom_img_a[%0d] got=%h exp=%h", i, o_rd_data_a, val(0, i)); end
      if (o_rd_data_b !== val(0, N + i)) begin n_fail++; $display("FAIL nom_img_b[%0d] got=%h exp=%h", i, o_rd_data_b, val(0, N + i)); end
    end
    finish_frame();
  endtask

  task automatic test_gaps();
    int ns, sc; bit to;
    run_frame(1, 1'b1, 2 * N - 1, -1, ns, sc, to);
    n_checks += 3;
    if (to !== 1'b0)    begin n_fail++; $display("FAIL gap_timeout got=%b exp=0", to); end
    if (ns != 1)        begin n_fail++; $display("FAIL gap_start_count got=%0d exp=1", ns); end
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL gap_err got=%b exp=0", o_err); end
    for (int i = 0; i < N; i++) begin
      i_rd_addr_a = 7'(i); i_rd_addr_b = 7'(i);
      step();
      n_checks += 2;
      if (o_rd_data_a !== val(1, i))     begin n_fail++; $display("FAIL gap_img_a[%0d] got=%h exp=%h", i, o_rd_data_a, val(1, i)); end
      if (o_rd_data_b !== val(1, N + i)) begin n_fail++; $display("FAIL gap_img_b[%0d] got=%h exp=%h", i, o_rd_data_b, val(1, N + i)); end
    end
    finish_frame();
  endtask

  task automatic test_mm_done();
    int ns, sc; bit to;
    run_frame(0, 1'b0, 2 * N - 1, N + 5, ns, sc, to);
    n_checks += 3;
    if (ns != 1)         begin n_fail++; $display("FAIL done_start_count got=%0d exp=1", ns); end
    if (sc != 2 * N + 1) begin n_fail++; $display("FAIL done_start_edge got=%0d exp=%0d", sc, 2 * N + 1); end
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL done_busy_wait got=%b exp=1", o_busy); end
    // mm_done in WAIT with arm held: IDLE for one cycle, then straight back into LOAD_A
    i_mm_done = 1'b1; i_arm = 1'b1;
    step();
    i_mm_done = 1'b0;
    n_checks += 2;
    if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL done_busy_idle got=%b exp=0", o_busy); end
    if (u_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready_idle got=%b exp=0", u_if.s_ready); end
    step();
    n_checks += 2;
    if (o_busy !== 1'b1)       begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", o_busy); end
    if (u_if.s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", u_if.s_ready); end
    i_arm = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_framing();
    int ns, sc; bit to;
    run_frame(0, 1'b0, 9, -1, ns, sc, to);
    n_checks += 3;
    if (to !== 1'b0)    begin n_fail++; $display("FAIL frm_timeout got=%b exp=0", to); end
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL frm_err got=%b exp=1", o_err); end
    if (ns != 1)        begin n_fail++; $display("FAIL frm_start_count got=%0d exp=1", ns); end
    finish_frame();
    run_frame(0, 1'b0, 2 * N - 1, -1, ns, sc, to);
    n_checks += 2;
    if (ns != 1)        begin n_fail++; $display("FAIL frm2_start_count got=%0d exp=1", ns); end
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL frm2_err_sticky got=%b exp=1", o_err); end
    finish_frame();
  endtask

  task automatic test_reset_midload();
    int ns, sc; bit to;
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    for (int i = 0; i < 30; i++) begin
      u_if.s_valid = 1'b1; u_if.s_data = val(1, i);
      step();
    end
    u_if.s_valid = 1'b0; resetn = 1'b0;
    step();
    n_checks += 4;
    if (u_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", u_if.s_ready); end
    if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy got=%b exp=0", o_busy); end
    if (o_mm_start !== 1'b0)   begin n_fail++; $display("FAIL mid_mm_start got=%b exp=0", o_mm_start); end
    if (o_err !== 1'b0)        begin n_fail++; $display("FAIL mid_err got=%b exp=0", o_err); end
    resetn = 1'b1;
    ns = 0;
    repeat (2 * N + 4) begin
      step();
      if (o_mm_start) ns++;
    end
    n_checks += 2;
    if (ns != 0)         begin n_fail++; $display("FAIL mid_no_start got=%0d exp=0", ns); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy got=%b exp=0", o_busy); end
    i_rd_addr_a = 7'd29;
    step();
    n_checks++;
    if (o_rd_data_a !== val(1, 29)) begin n_fail++; $display("FAIL mid_keep_a29 got=%h exp=%h", o_rd_data_a, val(1, 29)); end
    i_rd_addr_a = 7'd30;
    step();
    n_checks++;
    if (o_rd_data_a !== val(0, 30)) begin n_fail++; $display("FAIL mid_keep_a30 got=%h exp=%h", o_rd_data_a, val(0, 30)); end
    run_frame(0, 1'b0, 2 * N - 1, -1, ns, sc, to);
    n_checks += 2;
    if (to !== 1'b0) begin n_fail++; $display("FAIL reload_timeout got=%b exp=0", to); end
    if (ns != 1)     begin n_fail++; $display("FAIL reload_start_count got=%0d exp=1", ns); end
    for (int i = 0; i < 30; i++) begin
      i_rd_addr_a = 7'(i);
      step();
      n_checks++;
      if (o_rd_data_a !== val(0, i)) begin n_fail++; $display("FAIL reload_a[%0d] got=%h exp=%h", i, o_rd_data_a, val(0, i)); end
    end
    finish_frame();
  endtask

  task automatic test_rbw();
    int ns, sc; bit to;
    run_frame(2, 1'b0, 2 * N - 1, -1, ns, sc, to);
    n_checks++;
    if (ns != 1) begin n_fail++; $display("FAIL rbw_prep_start got=%0d exp=1", ns); end
    finish_frame();
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      u_if.s_valid = 1'b1; u_if.s_data = 8'hAA;
      if (i == 3) i_rd_addr_a = 7'd3;
      step();
    end
    n_checks++;
    if (o_rd_data_a !== 8'h11) begin n_fail++; $display("FAIL rbw_old got=%h exp=11", o_rd_data_a); end
    u_if.s_valid = 1'b0;
    step();
    n_checks++;
    if (o_rd_data_a !== 8'hAA) begin n_fail++; $display("FAIL rbw_new got=%h exp=aa", o_rd_data_a); end
    i_rd_addr_a = 7'd4;
    step();
    n_checks++;
    if (o_rd_data_a !== 8'h11) begin n_fail++; $display("FAIL rbw_untouched got=%h exp=11", o_rd_data_a); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gaps();
    test_mm_done();
    test_framing();
    test_reset_midload();
    test_rbw();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
